// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush/forward control for a 5-stage in-order pipeline.
// Revision    : 1.0
// ============================================================================
module pipeline_hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic [15:0] stall_count,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;
    localparam logic [7:0]  c_WAIT_MAX  = 8'hFF;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_stall_count;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_timeout;
    logic        w_hazard;
    logic        w_count_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))
            sel = 2'b10;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        w_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                    (id_uses_rs2 && (ex_rd == id_rs2)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_stall_count <= 16'd0;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_count_stall && (r_stall_count != c_STALL_MAX))
                r_stall_count <= r_stall_count + 16'd1;
            // Counter only runs while staying in MEM_WAIT; any exit clears it.
            if ((r_state == MEM_WAIT) && mem_busy) begin
                if (r_wait_cnt != c_WAIT_MAX)
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                if (r_wait_cnt == (c_WAIT_MAX - 8'd1))
                    r_mem_timeout <= 1'b1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        w_next_state  = RUN;
        w_count_stall = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        forward_a     = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        forward_b     = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            forward_a    = 2'b00;
            forward_b    = 2'b00;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            w_next_state = MEM_WAIT;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (w_hazard && (r_state != LU_STALL)) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_flush   = 1'b1;
            w_next_state  = LU_STALL;
            w_count_stall = 1'b1;
        end
    end

    assign stall_count = r_stall_count;
    assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// Directed bench for pipeline_hazard_controller with a cycle-level reference model.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
    logic        branch_taken, mem_busy;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        if_id_flush, id_ex_flush, mem_timeout;
    logic [1:0]  forward_a, forward_b;
    logic [15:0] stall_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit m_stall = 1'b0;
    bit m_wait = 1'b0;
    int m_wait_cycles = 0;
    int m_stalls = 0;
    bit m_timeout = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (mem_reg_write && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_hazard();
        return ex_mem_read && ex_rd != 5'd0 &&
               ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit hz;
        if (reset) begin
            m_stall = 1'b0; m_wait = 1'b0; m_wait_cycles = 0;
            m_stalls = 0; m_timeout = 1'b0;
        end else begin
            hz = !mem_busy && !branch_taken && !m_stall && exp_hazard();
            if (m_wait && mem_busy) m_wait_cycles++;
            else m_wait_cycles = 0;
            if (m_wait_cycles >= 255) m_timeout = 1'b1;
            if (hz && m_stalls < 65535) m_stalls++;
            m_stall = hz;
            m_wait  = mem_busy;
        end
    end

    always @(negedge clk) begin : cmp
        logic [5:0] e;  // {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush}
        logic [1:0] efa, efb;
        if (reset) begin
            e = 6'b000011; efa = 2'b00; efb = 2'b00;
        end else begin
            efa = exp_fwd(ex_rs1);
            efb = exp_fwd(ex_rs2);
            if (mem_busy)                        e = 6'b000000;
            else if (branch_taken)               e = 6'b111111;
            else if (!m_stall && exp_hazard())   e = 6'b001101;
            else                                 e = 6'b111100;
        end
        chk("pc_write",     pc_write,     e[5]);
        chk("if_id_write",  if_id_write,  e[4]);
        chk("id_ex_write",  id_ex_write,  e[3]);
        chk("ex_mem_write", ex_mem_write, e[2]);
        chk("if_id_flush",  if_id_flush,  e[1]);
        chk("id_ex_flush",  id_ex_flush,  e[0]);
        chk("forward_a",    forward_a,    efa);
        chk("forward_b",    forward_b,    efb);
        chk("stall_count",  stall_count,  m_stalls[15:0]);
        chk("mem_timeout",  mem_timeout,  m_timeout);
    end

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; mem_reg_write = 0;
        wb_reg_write = 0; branch_taken = 0; mem_busy = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu5();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    endtask

    initial begin
        clear_inputs();
        #1 reset = 1'b1;
        // Inputs that would otherwise stall/forward must be masked by reset
        mem_rd = 7; mem_reg_write = 1; ex_rs1 = 7; set_lu5(); mem_busy = 1;
        @(negedge clk);
        chk("lit_rst_fwd_a", forward_a, 2'b00);
        chk("lit_rst_pc_write", pc_write, 1'b0);
        chk("lit_rst_id_ex_flush", id_ex_flush, 1'b1);
        next(); next();
        reset = 1'b0; clear_inputs();
        @(negedge clk);
        chk("lit_idle_pc_write", pc_write, 1'b1);
        chk("lit_idle_if_id_flush", if_id_flush, 1'b0);
        next();

        // Load-use on rs1, held into the stall cycle to prove masking
        set_lu5();
        @(negedge clk);
        chk("lit_lu_pc_write", pc_write, 1'b0);
        chk("lit_lu_if_id_write", if_id_write, 1'b0);
        chk("lit_lu_id_ex_flush", id_ex_flush, 1'b1);
        chk("lit_lu_id_ex_write", id_ex_write, 1'b1);
        next();
        @(negedge clk);
        chk("lit_lu2_pc_write", pc_write, 1'b1);
        chk("lit_lu2_id_ex_flush", id_ex_flush, 1'b0);
        chk("lit_lu2_stall_count", stall_count, 16'd1);
        next(); clear_inputs();

        // Load-use on rs2
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_rs2 = 9; id_uses_rs2 = 1;
        next(); clear_inputs(); next();
        // Near-misses: unused rs2, x0, non-load
        ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; next();
        clear_inputs(); ex_mem_read = 1; id_uses_rs1 = 1;
        @(negedge clk);
        chk("lit_x0_pc_write", pc_write, 1'b1);
        next();
        clear_inputs(); ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; next();
        clear_inputs();

        // Branch overrides hazard
        set_lu5(); branch_taken = 1;
        @(negedge clk);
        chk("lit_br_if_id_flush", if_id_flush, 1'b1);
        chk("lit_br_id_ex_flush", id_ex_flush, 1'b1);
        chk("lit_br_pc_write", pc_write, 1'b1);
        next(); clear_inputs();
        @(negedge clk);
        chk("lit_br_stall_count", stall_count, 16'd2);
        next();

        // Branch arriving during LU_STALL
        set_lu5(); next();
        branch_taken = 1;
        @(negedge clk);
        chk("lit_br_stall_if_id_flush", if_id_flush, 1'b1);
        next(); clear_inputs(); next();

        // Memory wait swallows branch and hazard, branch applies on exit
        mem_busy = 1; branch_taken = 1; set_lu5();
        repeat (3) begin
            @(negedge clk);
            chk("lit_mw_pc_write", pc_write, 1'b0);
            chk("lit_mw_if_id_flush", if_id_flush, 1'b0);
            next();
        end
        mem_busy = 0;
        @(negedge clk);
        chk("lit_mw_exit_flush", if_id_flush, 1'b1);
        chk("lit_mw_exit_pc_write", pc_write, 1'b1);
        next(); clear_inputs();
        // Hazard on MEM_WAIT exit stalls as in RUN
        mem_busy = 1; next(); mem_busy = 0; set_lu5(); next(); clear_inputs(); next();

        // Forwarding priority
        mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_reg_write = 1; wb_reg_write = 1;
        @(negedge clk); chk("lit_fwd_mem", forward_a, 2'b10); next();
        mem_rd = 0;
        @(negedge clk); chk("lit_fwd_wb", forward_a, 2'b01); next();
        ex_rs1 = 0; wb_rd = 0;
        @(negedge clk); chk("lit_fwd_x0", forward_a, 2'b00); next();
        ex_rs2 = 12; wb_rd = 12; mem_rd = 12; mem_reg_write = 0;
        @(negedge clk); chk("lit_fwd_b_wb", forward_b, 2'b01); next();
        clear_inputs();

        // Watchdog
        mem_busy = 1;
        repeat (300) next();
        @(negedge clk); chk("lit_wd_set", mem_timeout, 1'b1);
        mem_busy = 0;
        repeat (3) next();
        @(negedge clk); chk("lit_wd_sticky", mem_timeout, 1'b1);
        next();

        // Reset during LU_STALL
        set_lu5(); next();
        reset = 1'b1;
        @(negedge clk);
        chk("lit_rs_pc_write", pc_write, 1'b0);
        chk("lit_rs_if_id_flush", if_id_flush, 1'b1);
        chk("lit_rs_stall_count", stall_count, 16'd0);
        chk("lit_rs_mem_timeout", mem_timeout, 1'b0);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("lit_rs_run_stall", pc_write, 1'b0);
        next(); clear_inputs(); next(); next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads rs1 / rs2.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- mem_rd, mem_reg_write  in  5, 1  EX/MEM destination and its write enable.
- wb_rd, wb_reg_write  in  5, 1  MEM/WB destination and its write enable.
- branch_taken  in  1  branch or jump resolved taken in EX.
- mem_busy  in  1  data memory has not completed its access this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  load enables for the PC and the pipeline registers.
- if_id_flush, id_ex_flush  out  1 each  zero the pipeline register (bubble).
- forward_a, forward_b  out  2 each  EX operand mux select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- stall_count  out  16  count of load-use bubbles inserted, saturating.
- mem_timeout  out  1  sticky memory-wait watchdog flag.
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-high, with ports named clk and reset.

Function
REQ-003 SHALL implement the states RUN, LU_STALL and MEM_WAIT. The next state SHALL be resolved in this priority order: mem_busy, then branch_taken, then load-use hazard.
REQ-004 A load-use hazard SHALL be defined as: ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and ex_rd==id_rs1) or (id_uses_rs2 and ex_rd==id_rs2)).
REQ-005 In RUN, with no event, SHALL drive all write enables to 1 and all flushes to 0.
REQ-006 In RUN, on a load-use hazard, SHALL in the same cycle drive pc_write=0, if_id_write=0, id_ex_flush=1, and id_ex_write=1 and ex_mem_write=1. SHALL then go to LU_STALL and increment stall_count, saturating at 0xFFFF.
REQ-007 LU_STALL SHALL last exactly one cycle with normal enables and hazard detection masked, then return to RUN, so that exactly one bubble is inserted per load.
REQ-008 In RUN or LU_STALL, on branch_taken=1 with mem_busy=0, SHALL drive if_id_flush=1 and id_ex_flush=1 with pc_write=1 in the same cycle. The branch SHALL override a simultaneous load-use hazard: no stall and no count increment.
REQ-009 Whenever mem_busy=1 in any state, SHALL drive pc_write, if_id_write, id_ex_write and ex_mem_write to 0 and both flushes to 0, ignore branch_taken and hazards, and enter or remain in MEM_WAIT.
REQ-010 In MEM_WAIT with mem_busy=0, SHALL return to RUN and evaluate that cycle as RUN.
REQ-011 An 8-bit wait counter SHALL increment on each MEM_WAIT cycle and clear on leaving MEM_WAIT. When it reaches 255, mem_timeout SHALL be set and SHALL remain 1 until reset.
REQ-012 Forwarding SHALL be combinational in every state:
- forward_a=10 when mem_reg_write=1, mem_rd!=0 and mem_rd==ex_rs1;
- otherwise forward_a=01 when wb_reg_write=1, wb_rd!=0 and wb_rd==ex_rs1;
- otherwise forward_a=00.
- forward_b SHALL follow the same rules using ex_rs2.
REQ-013 Register x0 SHALL never trigger a stall or a forward.

Reset
REQ-014 While reset=1, SHALL force:
- state = RUN;
- stall_count = 0, wait counter = 0, mem_timeout = 0;
- pc_write, if_id_write, id_ex_write, ex_mem_write = 0;
- if_id_flush = 1, id_ex_flush = 1;
- forward_a = 00, forward_b = 00.
REQ-015 Reset asserted mid-stall or mid-wait SHALL abort the operation immediately. The first cycle after release SHALL be RUN.

Verification
REQ-016 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all enables 1; stall_count=1.
REQ-017 Branch plus hazard together: conditions of REQ-016 with branch_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1; stall_count unchanged.
REQ-018 Memory wait: mem_busy=1 for 3 cycles with branch_taken=1 -> all four enables 0 and no flush for 3 cycles. On the 4th cycle (mem_busy=0, branch_taken=1) -> flushes asserted.
REQ-019 Forwarding priority: mem_rd=wb_rd=ex_rs1=7, both write enables 1 -> forward_a=10. With mem_rd=0 -> forward_a=01. With ex_rs1=0 -> forward_a=00.
REQ-020 Watchdog: mem_busy=1 held for 300 cycles -> mem_timeout=1 from cycle 255 onward, still 1 after mem_busy drops, cleared only by reset.
REQ-021 Reset mid-stall: assert reset during LU_STALL -> outputs match REQ-014 immediately; after release the block is in RUN with stall_count=0.
